tile_draw_sequencer: RTL and testbench
======================================

TILE_DRAW_SEQUENCER -- requirements
Module: tile_draw_sequencer

Interface
REQ-001 Parameter DRAW_CYCLES, default 141: enabled cycles one number drawer needs to finish one glyph.
REQ-002 Parameter TILE_PITCH, default 30: pixel spacing between tile origins, both axes.
REQ-003 Parameter BOARD_X0, default 20; BOARD_Y0, default 0: pixel origin of tile 0.
REQ-004 Reset resetn, synchronous, active-low; clock clk.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 resetn  input  1  synchronous active-low reset.
REQ-007 start  input  1  request one full board redraw; sampled only in IDLE.
REQ-008 board  input  64  16 tiles x 4 bits, tile i at bits [4i+3:4i], row-major; value 0 = blank.
REQ-009 drawer_sel  output  4  tile value selecting which number drawer drives the pixel mux.
REQ-010 drawer_enable  output  1  enable to the selected number drawer.
REQ-011 drawer_resetn  output  1  active-low synchronous clear to all number drawers.
REQ-012 tile_x  output  8  pixel x origin of the current tile; tile_y output 7, pixel y origin.
REQ-013 plot  output  1  pixel-write strobe to the VGA adapter, equal to drawer_enable.
REQ-014 busy  output  1  high in every state except IDLE; done output 1, one-cycle completion pulse.

Function
REQ-015 States: IDLE, SCAN, CLEAR, DRAW, DONE.
REQ-016 IDLE with start=1: latch board into board_q, idx<=0, go to SCAN; board changes after the latch are ignored.
REQ-017 SCAN with board_q[idx]!=0: drawer_sel<=board_q[idx], go to CLEAR.
REQ-018 SCAN with board_q[idx]==0 (blank tile): if idx==15 go to DONE, else idx<=idx+1 and stay in SCAN; no clear and no plot for blank tiles.
REQ-019 CLEAR: exactly one cycle with drawer_resetn=0; then go to DRAW with cnt<=0.
REQ-020 DRAW: drawer_enable=1 and plot=1 for exactly DRAW_CYCLES consecutive cycles, with cnt counting 0..DRAW_CYCLES-1.
REQ-021 DRAW at cnt==DRAW_CYCLES-1: if idx==15 go to DONE, else idx<=idx+1 and go to SCAN.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE; start in DONE is ignored.
REQ-023 tile_x=BOARD_X0+(idx%4)*TILE_PITCH and tile_y=BOARD_Y0+(idx/4)*TILE_PITCH; compute in 8/7-bit unsigned; defaults must not overflow.
REQ-024 tile_x, tile_y and drawer_sel stay stable for the whole CLEAR+DRAW span of a tile.
REQ-025 drawer_resetn=1 in all states except CLEAR; drawer_enable=0 outside DRAW.
REQ-026 Latency: start accepted at edge N gives SCAN in cycle N+1; for a non-blank tile 0, CLEAR in N+2 and first plot in N+3.
REQ-027 All 16 tiles non-blank: exactly 16*(DRAW_CYCLES+2) cycles from the first SCAN to DONE.
REQ-028 All tiles blank: 16 SCAN cycles, then DONE; plot never asserts.

Reset
REQ-029 resetn=0 at any time, including mid-DRAW, forces IDLE on the next edge.
REQ-030 Reset values: idx=0, cnt=0, drawer_sel=0, board_q=0, drawer_enable=0, plot=0, drawer_resetn=0 while resetn=0, busy=0, done=0.

Structure
REQ-031 The shared package shall hold the state enumeration, NUM_TILES=16, the tile bit width (4) and the default pitch/origin constants.
REQ-032 Tile-origin arithmetic shall live in one combinational sub-module, tile_origin_calc (idx -> tile_x, tile_y).

Verification
REQ-033 DRAW_CYCLES=4, board = tile 0 value 5, all other tiles 0; pulse start -> drawer_sel=5, one CLEAR cycle, plot high 4 cycles at (20,0), done 15 SCAN cycles later.
REQ-034 DRAW_CYCLES=4, all 16 tiles non-blank -> plot high for 64 cycles total; done exactly 96 cycles after the first SCAN; tile 15 drawn at (110,90).
REQ-035 All-blank board -> plot never high; done pulse 17 cycles after start; busy falls with done.
REQ-036 Assert resetn=0 during the 3rd DRAW cycle of tile 2 -> next cycle is IDLE, all outputs at reset values; a new start redraws from tile 0.
REQ-037 Hold start high through an entire redraw and change board mid-draw -> exactly one redraw per IDLE acceptance, using the board value latched at start.

Source files
------------

// File: rtl/tile_draw_sequencer_pkg.sv
// Shared types and constants for the tile board redraw sequencer.
package tile_draw_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_CLEAR = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int NUM_TILES       = 16;
  localparam int TILE_W          = 4;
  localparam int IDX_W           = 4;
  localparam int BOARD_W         = NUM_TILES * TILE_W;
  localparam int DEF_DRAW_CYCLES = 141;
  localparam int DEF_TILE_PITCH  = 30;
  localparam int DEF_BOARD_X0    = 20;
  localparam int DEF_BOARD_Y0    = 0;

endpackage

// File: rtl/tile_origin_calc.sv
// Maps a row-major tile index on the 4x4 board to its pixel origin.
module tile_origin_calc
  import tile_draw_sequencer_pkg::*;
#(
  parameter int TILE_PITCH = DEF_TILE_PITCH,
  parameter int BOARD_X0   = DEF_BOARD_X0,
  parameter int BOARD_Y0   = DEF_BOARD_Y0
) (
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       tile_x,
  output logic [6:0]       tile_y
);

  localparam logic [7:0] PITCH_X = 8'(TILE_PITCH);
  localparam logic [7:0] ORIGIN_X = 8'(BOARD_X0);
  localparam logic [6:0] PITCH_Y = 7'(TILE_PITCH);
  localparam logic [6:0] ORIGIN_Y = 7'(BOARD_Y0);

  logic [7:0] col;
  logic [6:0] row;

  // Low two index bits select the column, high two the row.
  assign col    = {6'd0, idx[1:0]};
  assign row    = {5'd0, idx[3:2]};
  assign tile_x = ORIGIN_X + col * PITCH_X;
  assign tile_y = ORIGIN_Y + row * PITCH_Y;

endmodule

// File: rtl/tile_draw_sequencer.sv
// Walks a latched 16-tile board, clearing and enabling one number drawer per non-blank tile.
module tile_draw_sequencer
  import tile_draw_sequencer_pkg::*;
#(
  parameter int DRAW_CYCLES = DEF_DRAW_CYCLES,
  parameter int TILE_PITCH  = DEF_TILE_PITCH,
  parameter int BOARD_X0    = DEF_BOARD_X0,
  parameter int BOARD_Y0    = DEF_BOARD_Y0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [BOARD_W-1:0] board,
  output logic [TILE_W-1:0]  drawer_sel,
  output logic               drawer_enable,
  output logic               drawer_resetn,
  output logic [7:0]         tile_x,
  output logic [6:0]         tile_y,
  output logic               plot,
  output logic               busy,
  output logic               done,
  output state_t             fsm_state
);

  localparam int CNT_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAW_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TILES - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [BOARD_W-1:0] board_q;
  logic [TILE_W-1:0]  cur_tile;

  assign cur_tile  = board_q[{idx, 2'b00} +: TILE_W];
  assign fsm_state = state;

  tile_origin_calc #(
    .TILE_PITCH (TILE_PITCH),
    .BOARD_X0   (BOARD_X0),
    .BOARD_Y0   (BOARD_Y0)
  ) u_origin (
    .idx    (idx),
    .tile_x (tile_x),
    .tile_y (tile_y)
  );

  // start is a level request honoured only in IDLE; busy covers SCAN..DONE,
  // and done pulses for the single DONE cycle. Outputs are registered with
  // the transition into the state they belong to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      idx           <= '0;
      cnt           <= '0;
      board_q       <= '0;
      drawer_sel    <= '0;
      drawer_enable <= 1'b0;
      plot          <= 1'b0;
      drawer_resetn <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      drawer_resetn <= 1'b1;
      drawer_enable <= 1'b0;
      plot          <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            board_q <= board;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (cur_tile != '0) begin
            drawer_sel    <= cur_tile;
            drawer_resetn <= 1'b0;
            state         <= S_CLEAR;
          end else if (idx == IDX_LAST) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_CLEAR: begin
          cnt           <= '0;
          drawer_enable <= 1'b1;
          plot          <= 1'b1;
          state         <= S_DRAW;
        end
        S_DRAW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SCAN;
            end
          end else begin
            cnt           <= cnt + 1'b1;
            drawer_enable <= 1'b1;
            plot          <= 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_draw_sequencer.sv
// Directed bench for tile_draw_sequencer with a 4-cycle drawer.
module tb_tile_draw_sequencer;
  import tile_draw_sequencer_pkg::*;

  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  board = '0;
  logic [3:0]   drawer_sel;
  logic         drawer_enable;
  logic         drawer_resetn;
  logic [7:0]   tile_x;
  logic [6:0]   tile_y;
  logic         plot;
  logic         busy;
  logic         done;
  state_t       fsm_state;

  int checks = 0;
  int failures = 0;

  logic [18:0] exp_q[$];

  typedef struct {
    int         n;
    logic       start;
    state_t     st;
    logic       plot;
    logic       drn;
    logic [3:0] sel;
    logic       chk_xy;
    logic [7:0] x;
    logic [6:0] y;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[7];

  tile_draw_sequencer #(.DRAW_CYCLES(DC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .board         (board),
    .drawer_sel    (drawer_sel),
    .drawer_enable (drawer_enable),
    .drawer_resetn (drawer_resetn),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .plot          (plot),
    .busy          (busy),
    .done          (done),
    .fsm_state     (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [18:0] tile_exp(input int i, input int v);
    return {4'(v), 8'(20 + (i % 4) * 30), 7'((i / 4) * 30)};
  endfunction

  // Steps from the acceptance edge until done; compares each CLEAR against exp_q.
  task automatic run_redraw(input string tag, input int budget, input logic hold_start,
                            input logic swap_board, input logic [63:0] new_board,
                            output int edges, output int plots);
    logic [18:0] cur;
    logic [18:0] e;
    int en_err;
    int stab_err;
    logic seen_done;
    cur = '0; en_err = 0; stab_err = 0; seen_done = 1'b0;
    edges = 0; plots = 0;
    while (!seen_done && edges < budget) begin
      tick();
      edges++;
      if (!hold_start) start = 1'b0;
      if (plot) plots++;
      if (plot !== drawer_enable) en_err++;
      if (fsm_state == S_CLEAR) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s extra_tile sel=%0d x=%0d y=%0d", tag, drawer_sel, tile_x, tile_y);
        end else begin
          e = exp_q.pop_front();
          cur = {drawer_sel, tile_x, tile_y};
          check($sformatf("%s tile_sel_x_y", tag), cur, e);
        end
      end
      if (fsm_state == S_DRAW && {drawer_sel, tile_x, tile_y} !== cur) stab_err++;
      if (swap_board && fsm_state == S_DRAW) board = new_board;
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
      end
    end
    check($sformatf("%s done_seen", tag), seen_done, 1);
    check($sformatf("%s tiles_left", tag), exp_q.size(), 0);
    check($sformatf("%s plot_ne_enable", tag), en_err, 0);
    check($sformatf("%s origin_unstable", tag), stab_err, 0);
    exp_q.delete();
  endtask

  initial begin
    int edges;
    int plots;
    int clears;
    int draws;

    // Single tile 0 = 5; the first IDLE row also proves start in DONE is ignored.
    vecs[0] = '{1,  1'b1, S_SCAN,  1'b0, 1'b1, 4'd0, 1'b1, 8'd20, 7'd0, 1'b1, 1'b0};
    vecs[1] = '{1,  1'b0, S_CLEAR, 1'b0, 1'b0, 4'd5, 1'b1, 8'd20, 7'd0, 1'b1, 1'b0};
    vecs[2] = '{DC, 1'b0, S_DRAW,  1'b1, 1'b1, 4'd5, 1'b1, 8'd20, 7'd0, 1'b1, 1'b0};
    vecs[3] = '{15, 1'b0, S_SCAN,  1'b0, 1'b1, 4'd5, 1'b0, 8'd0,  7'd0, 1'b1, 1'b0};
    vecs[4] = '{1,  1'b0, S_DONE,  1'b0, 1'b1, 4'd5, 1'b0, 8'd0,  7'd0, 1'b1, 1'b1};
    vecs[5] = '{1,  1'b1, S_IDLE,  1'b0, 1'b1, 4'd5, 1'b0, 8'd0,  7'd0, 1'b0, 1'b0};
    vecs[6] = '{2,  1'b0, S_IDLE,  1'b0, 1'b1, 4'd5, 1'b0, 8'd0,  7'd0, 1'b0, 1'b0};

    resetn = 1'b0;
    tick();
    tick();
    check("reset_outputs",
          {fsm_state, plot, drawer_enable, drawer_resetn, drawer_sel, busy, done, tile_x, tile_y},
          {S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd20, 7'd0});
    resetn = 1'b1;
    tick();
    check("idle_after_reset", {fsm_state, drawer_resetn, busy}, {S_IDLE, 1'b1, 1'b0});

    board = 64'h5;
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        start = vecs[i].start;
        tick();
        check($sformatf("vec%0d.%0d", i, c),
              {fsm_state, plot, drawer_enable, drawer_resetn, drawer_sel, busy, done},
              {vecs[i].st, vecs[i].plot, vecs[i].plot, vecs[i].drn, vecs[i].sel,
               vecs[i].busy, vecs[i].done});
        if (vecs[i].chk_xy)
          check($sformatf("vec%0d.%0d_xy", i, c), {tile_x, tile_y}, {vecs[i].x, vecs[i].y});
      end
    end
    start = 1'b0;

    // All tiles non-blank: values 1..15, tile 15 = 1.
    for (int i = 0; i < 16; i++) begin
      board[4*i +: 4] = 4'((i % 15) + 1);
      exp_q.push_back(tile_exp(i, (i % 15) + 1));
    end
    check("tile15_origin", exp_q[15], {4'd1, 8'd110, 7'd90});
    start = 1'b1;
    run_redraw("full", 400, 1'b0, 1'b0, '0, edges, plots);
    check("full_edges_to_done", edges, 97);
    check("full_plot_cycles", plots, 64);
    tick();
    check("full_back_idle", {fsm_state, busy, done}, {S_IDLE, 1'b0, 1'b0});

    // All blank.
    board = '0;
    start = 1'b1;
    run_redraw("blank", 100, 1'b0, 1'b0, '0, edges, plots);
    check("blank_edges_to_done", edges, 17);
    check("blank_plot_cycles", plots, 0);
    check("blank_busy_at_done", busy, 1);
    tick();
    check("blank_busy_falls", {fsm_state, busy, done}, {S_IDLE, 1'b0, 1'b0});

    // Reset during the third DRAW cycle of tile 2.
    board = 64'h321;
    start = 1'b1;
    tick();
    start = 1'b0;
    clears = 0;
    draws = 0;
    for (int k = 0; k < 100 && draws < 3; k++) begin
      tick();
      if (fsm_state == S_CLEAR) clears++;
      if (clears == 3 && fsm_state == S_DRAW) draws++;
    end
    check("reached_tile2_draw3", {clears[7:0], draws[7:0], fsm_state}, {8'd3, 8'd3, S_DRAW});
    resetn = 1'b0;
    tick();
    check("mid_draw_reset",
          {fsm_state, plot, drawer_enable, drawer_resetn, drawer_sel, busy, done, tile_x, tile_y},
          {S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd20, 7'd0});
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) exp_q.push_back(tile_exp(i, i + 1));
    start = 1'b1;
    run_redraw("redraw", 200, 1'b0, 1'b0, '0, edges, plots);
    check("redraw_plot_cycles", plots, 3 * DC);
    tick();

    // start held high, board changed mid-draw: latched board wins, one redraw only.
    board = '0;
    board[4*3 +: 4] = 4'd9;
    board[4*12 +: 4] = 4'd4;
    exp_q.push_back(tile_exp(3, 9));
    exp_q.push_back(tile_exp(12, 4));
    start = 1'b1;
    run_redraw("held", 200, 1'b1, 1'b1, {16{4'hF}}, edges, plots);
    check("held_edges_to_done", edges, 1 + 16 + 2 * (DC + 1));
    check("held_plot_cycles", plots, 2 * DC);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("held_stays_idle%0d", k), {fsm_state, busy, done}, {S_IDLE, 1'b0, 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
